binary_counter: RTL and testbench
=================================

# binary_counter

Free-running, up-counting binary counter with asynchronous active-high reset. It advances by one on every rising clock edge while out of reset, and wraps modulo 2^WIDTH. It serves as a basic timing and sequence source for downstream logic. It also provides a terminal-count flag that downstream logic may use for cascading or rollover detection.

## Interface
Parameters:
- WIDTH, default 4: counter width in bits; legal range 1 to 32.
- RESET_VALUE, default 0: value loaded into count while rst is high; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates occur on its rising edge.
- rst  input  1  reset, asynchronous and active-high; forces count to RESET_VALUE.
- count  output  WIDTH  current counter value, driven directly from a register.
- terminal  output  1  high whenever count equals 2^WIDTH-1 (all ones); purely combinational decode of count.

## Operation
- Single register count[WIDTH-1:0]; no other state.
- rst high: count = RESET_VALUE immediately, without waiting for clk, and held for as long as rst stays high. Clock edges during reset have no effect.
- rst low: on each rising clk edge, count <= count + 1, truncated to WIDTH bits.
- Wrap-around: all ones (15 for WIDTH=4) is followed by 0 on the next edge. No saturation, and no sticky overflow flag.
- terminal = (count == all ones). With RESET_VALUE=0 it is low during reset.
- No enable, load or direction control. The counter increments on every non-reset edge.
- Outputs carry no X after the first rst assertion. Before the first reset, count is undefined; the system must reset at power-up.

## Timing
- Reset assertion is asynchronous. count reaches RESET_VALUE in the same simulation time step as rst rises, independent of clk.
- Reset release is effective at the first rising clk edge strictly after rst falls. That edge loads RESET_VALUE+1.
- If rst falls exactly coincident with a rising edge, that edge is treated as in reset and does not increment.
- Latency: one clock from edge to new count. terminal follows count combinationally with zero added cycles.
- Values sampled at a rising edge (pre-update) show the previous count. Example, 10 ns period, first edge at 5 ns, rst high 0–10 ns:
  - Edge 5 ns: sampled 0.
  - Edge 15 ns: sampled 0, count becomes 1.
  - Edges 25, 35 and 45 ns: sampled 1, 2 and 3.
- Reset mid-count: asserting rst at any count value returns count to RESET_VALUE asynchronously. Counting resumes from there after release.
- Period of the count sequence is 2^WIDTH clocks. terminal is high for exactly 1 clock per period.

## Test plan
- Power-up reset: rst=1 from t=0 for 10 ns with a 10 ns clock period. Required: count=0 at 1 ns, before any clock edge. Values sampled at the edges at 5, 15, 25, 35 and 45 ns are 0, 0, 1, 2 and 3.
- Wrap: release reset and run 17 edges. Required:
  - count runs 1..15, then 0, then 1.
  - terminal is high only while count=15, for exactly one cycle.
- Asynchronous reset mid-count: at count=9, pulse rst for 3 ns between clock edges. Required: count=0 within the pulse, with no clock edge involved. The first edge after release gives count=1.
- Reset held across edges: hold rst=1 for 5 rising edges. Required: count remains 0 throughout and terminal remains 0.
- Reset release coincident with a clock edge: drop rst at the same time step as a rising edge. Required: count stays 0 at that edge and becomes 1 at the next edge.
- Parameter variation: WIDTH=3 with RESET_VALUE=5. Required:
  - count=5 during reset.
  - After release the sequence is 6, 7, 0, 1.
  - terminal is high at count=7.

Source files
------------

// File: rtl/binary_counter.sv
// Free-running up-counter, wraps modulo 2^WIDTH, with asynchronous active-high reset
// and a combinational all-ones terminal-count flag for cascading or rollover detection.
module binary_counter #(
   parameter int WIDTH       = 4,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Truncating add gives the all-ones -> zero wrap with no carry kept.
   always_comb begin
      count_d = count_q + ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign terminal = (count_q == ALL_ONES);

endmodule

// File: tb/tb_binary_counter.sv
// Directed bench for binary_counter: a default 4-bit instance and a WIDTH=3/RESET_VALUE=5
// instance, checked against a scoreboard of expected counts filled as stimulus is applied.
module tb_binary_counter;

   logic       clk;
   logic       rst_a;
   logic       rst_b;
   logic [3:0] cnt_a;
   logic       term_a;
   logic [2:0] cnt_b;
   logic       term_b;

   int n_cmp = 0;
   int n_err = 0;
   int qa[$];
   int qb[$];
   int m;
   int term_hits;

   binary_counter #(.WIDTH(4), .RESET_VALUE(0)) dut_a (
      .clk      (clk),
      .rst      (rst_a),
      .count    (cnt_a),
      .terminal (term_a)
   );

   binary_counter #(.WIDTH(3), .RESET_VALUE(5)) dut_b (
      .clk      (clk),
      .rst      (rst_b),
      .count    (cnt_b),
      .terminal (term_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_a(input string tag);
      int  e;
      logic te;
      if (qa.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s scoreboard A empty", tag);
         return;
      end
      e  = qa.pop_front();
      te = (e == 15);
      n_cmp++;
      assert (cnt_a === 4'(e))
      else begin
         n_err++;
         $error("FAIL %s count observed=%0d expected=%0d", tag, cnt_a, e);
      end
      n_cmp++;
      assert (term_a === te)
      else begin
         n_err++;
         $error("FAIL %s terminal observed=%b expected=%b", tag, term_a, te);
      end
      if (term_a === 1'b1) term_hits++;
   endtask

   task automatic chk_b(input string tag);
      int  e;
      logic te;
      if (qb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s scoreboard B empty", tag);
         return;
      end
      e  = qb.pop_front();
      te = (e == 7);
      n_cmp++;
      assert (cnt_b === 3'(e))
      else begin
         n_err++;
         $error("FAIL %s count observed=%0d expected=%0d", tag, cnt_b, e);
      end
      n_cmp++;
      assert (term_b === te)
      else begin
         n_err++;
         $error("FAIL %s terminal observed=%b expected=%b", tag, term_b, te);
      end
   endtask

   // Pre-edge sample point: 1 ns before the next rising edge.
   task automatic pre_edge();
      @(negedge clk);
      #4;
   endtask

   initial begin
      term_hits = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Power-up reset, before any clock edge.
      #1;
      qa.push_back(0); chk_a("por_t1");
      qb.push_back(5); chk_b("por_b_t1");
      #3;
      qa.push_back(0); chk_a("por_edge5");

      @(negedge clk);
      rst_a = 1'b0;
      #4;
      qa.push_back(0); chk_a("por_edge15");

      // 17 edges: 1..15, 0, 1; terminal only at 15.
      m = 0;
      for (int i = 0; i < 17; i++) begin
         m = (m + 1) % 16;
         qa.push_back(m);
         pre_edge();
         chk_a($sformatf("wrap_%0d", i));
      end
      n_cmp++;
      assert (term_hits == 1)
      else begin
         n_err++;
         $error("FAIL wrap_term_hits observed=%0d expected=1", term_hits);
      end

      // Run up to 9, then async pulse between edges.
      while (m != 9) begin
         @(posedge clk);
         m = (m + 1) % 16;
      end
      #1;
      qa.push_back(9); chk_a("mid_before");
      rst_a = 1'b1;
      #1;
      qa.push_back(0); chk_a("mid_async");
      #2;
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      qa.push_back(1); chk_a("mid_release");

      // Reset held across 5 edges.
      rst_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         qa.push_back(0); chk_a($sformatf("hold_%0d", i));
      end

      // Release in the same time step as a rising edge: that edge stays in reset.
      @(posedge clk);
      rst_a <= 1'b0;
      #1;
      qa.push_back(0); chk_a("coinc_edge");
      @(posedge clk);
      #1;
      qa.push_back(1); chk_a("coinc_next");

      // WIDTH=3, RESET_VALUE=5 instance: held in reset all along, then released.
      qb.push_back(5); chk_b("b_held");
      @(negedge clk);
      rst_b = 1'b0;
      m = 5;
      for (int i = 0; i < 4; i++) begin
         m = (m + 1) % 8;
         qb.push_back(m);
         @(posedge clk);
         #1;
         chk_b($sformatf("b_seq_%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
